audio_bram_arbiter: RTL
=======================

AUDIO_BRAM_ARBITER -- requirements
Module: audio_bram_arbiter

Interface
REQ-001 SHALL have parameter MAX_GRANT, default 32'd100000000, meaning the maximum number of clkout_sys cycles one grant may last.
REQ-002 SHALL have parameter TURN_CYCLES, default 4'd2, meaning the number of dead cycles between grants (legal range 1-15).
REQ-003 SHALL have port clkout_sys  input  1  system clock, with all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rec_req  input  1  recorder requests BRAM ownership.
REQ-006 SHALL have port rec_we  input  1  recorder write strobe.
REQ-007 SHALL have port rec_addr  input  16  recorder BRAM address.
REQ-008 SHALL have port rec_wdata  input  32  recorder write data.
REQ-009 SHALL have port play_req  input  1  playback requests BRAM ownership.
REQ-010 SHALL have port play_addr  input  16  playback BRAM address.
REQ-011 SHALL have port bram_rdata  input  32  BRAM read data, valid 1 cycle after the address.
REQ-012 SHALL have outputs rec_gnt 1, play_gnt 1, bram_we 1, bram_addr 16, bram_wdata 32, play_rdata 32, busy 1 and state_dbg 2, each an output.

Function
REQ-013 SHALL implement FSM states IDLE=2'b00, REC=2'b01, PLAY=2'b10 and TURN=2'b11, and state_dbg SHALL equal the current state.
REQ-014 In IDLE, an eligible rec_req SHALL move to REC, else an eligible play_req SHALL move to PLAY, else the FSM SHALL stay in IDLE.
REQ-015 rec_gnt SHALL be 1 exactly in REC, and play_gnt SHALL be 1 exactly in PLAY, both registered, so the first grant is seen 1 cycle after the request is sampled.
REQ-016 In REC, bram_addr=rec_addr, bram_we=rec_we and bram_wdata=rec_wdata, all combinational.
REQ-017 In PLAY, bram_addr=play_addr and bram_we=0.
REQ-018 Outside REC and PLAY, bram_addr=0, bram_we=0 and bram_wdata=0.
REQ-019 play_rdata SHALL register bram_rdata on every cycle where play_gnt was 1 on the previous cycle, and SHALL otherwise hold its value.
REQ-020 There SHALL be no preemption: deassertion of the owner's request SHALL move the FSM to TURN on the next edge.
REQ-021 A 32-bit grant counter SHALL clear on grant entry and increment each owned cycle.
REQ-022 When the grant counter reaches MAX_GRANT-1, the FSM SHALL move to TURN and set the owner's lockout flag.
REQ-023 A locked requester SHALL be ineligible until its req is sampled 0, and SHALL then be unlocked.
REQ-024 TURN SHALL last exactly TURN_CYCLES cycles, counted by a 4-bit counter, and then go to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A request asserted and deasserted while the other requester owns the BRAM SHALL be ignored, because requests are level-sensitive and not latched.
REQ-027 When rec_req and play_req rise in the same cycle in IDLE, REQ-014 or REQ-033 SHALL decide the winner.
REQ-028 A request deasserting on the same edge that the timeout fires SHALL still set the lockout flag, which clears on the following sampled-0 cycle.

Reset
REQ-029 Reset SHALL force state=IDLE, both grants=0, bram_we=0, bram_addr=0, bram_wdata=0, play_rdata=0, busy=0, both counters=0 and both lockout flags=0.
REQ-030 Reset asserted mid-grant SHALL drop the grant and bram_we within the same cycle, asynchronously.
REQ-031 After reset release, the first arbitration SHALL occur on the first rising edge where a request is sampled 1.

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-033 When ARB_ROUND_ROBIN_EN is defined, a 1-bit last-owner register (reset value: play) SHALL decide simultaneous requests in IDLE, and the requester that did not own last SHALL win.
REQ-034 When ARB_ROUND_ROBIN_EN is undefined, fixed recorder priority SHALL apply and no last-owner register SHALL exist.

Verification
REQ-035 Bench SHALL drive rec_req=1 from reset, with rec_we=1, rec_addr=16'h8020 and rec_wdata=32'hDEADBEEF, and SHALL check rec_gnt=1 after 1 cycle, bram_we=1, bram_addr=16'h8020 and bram_wdata=32'hDEADBEEF.
REQ-036 Bench SHALL drop rec_req in REC with TURN_CYCLES=2 and SHALL check 2 cycles of state_dbg=2'b11, then IDLE, then play_gnt=1 if play_req is held.
REQ-037 Bench SHALL raise rec_req and play_req in the same cycle, twice, and SHALL check rec_gnt both times without ARB_ROUND_ROBIN_EN, and rec_gnt then play_gnt with it.
REQ-038 Bench SHALL hold play_req with MAX_GRANT=10 and SHALL check play_gnt high for exactly 10 cycles, then TURN, then no regrant until play_req is sampled 0 and raised again.
REQ-039 Bench SHALL set bram_rdata=32'h12345678 in PLAY and SHALL check play_rdata=32'h12345678 one cycle later and held after the grant ends.
REQ-040 Bench SHALL assert reset mid-REC with rec_we=1 and SHALL check bram_we=0, rec_gnt=0 and state_dbg=2'b00 before the next clock edge.

Source files
------------

// File: rtl/audio_bram_arbiter.sv
// Audio BRAM arbiter: hands one BRAM port to the recorder or to playback, with a grant timeout and turnaround gap.
// Define ARB_ROUND_ROBIN_EN to alternate the winner of simultaneous requests; the default is fixed recorder priority.
module audio_bram_arbiter #(
  parameter logic [31:0] MAX_GRANT   = 32'd100000000,
  parameter logic [3:0]  TURN_CYCLES = 4'd2
) (
  input  logic        clkout_sys,
  input  logic        reset,
  input  logic        rec_req,
  input  logic        rec_we,
  input  logic [15:0] rec_addr,
  input  logic [31:0] rec_wdata,
  input  logic        play_req,
  input  logic [15:0] play_addr,
  input  logic [31:0] bram_rdata,
  output logic        rec_gnt,
  output logic        play_gnt,
  output logic        bram_we,
  output logic [15:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [31:0] play_rdata,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REC  = 2'b01,
    PLAY = 2'b10,
    TURN = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] grant_cnt;
  logic [3:0]  turn_cnt;
  logic        lock_rec, lock_play;
  logic        set_lock_rec, set_lock_play;
  logic        play_gnt_q;
  logic        rec_elig, play_elig, rec_wins, grant_done;

  assign rec_elig   = rec_req & ~lock_rec;
  assign play_elig  = play_req & ~lock_play;
  assign grant_done = (grant_cnt == MAX_GRANT - 32'd1);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_play;

  // On a tie the recorder wins only if playback owned the BRAM last.
  assign rec_wins = rec_elig & (~play_elig | last_play);

  always_ff @(posedge clkout_sys or posedge reset) begin
    if (reset)                                   last_play <= 1'b1;
    else if (state_q == IDLE && state_d == REC)  last_play <= 1'b0;
    else if (state_q == IDLE && state_d == PLAY) last_play <= 1'b1;
  end
`else
  assign rec_wins = rec_elig;
`endif

  always_comb begin
    state_d       = state_q;
    set_lock_rec  = 1'b0;
    set_lock_play = 1'b0;
    case (state_q)
      IDLE: begin
        if (rec_wins)       state_d = REC;
        else if (play_elig) state_d = PLAY;
      end
      REC: begin
        if (grant_done) begin
          state_d      = TURN;
          set_lock_rec = 1'b1;
        end else if (!rec_req) begin
          state_d = TURN;
        end
      end
      PLAY: begin
        if (grant_done) begin
          state_d       = TURN;
          set_lock_play = 1'b1;
        end else if (!play_req) begin
          state_d = TURN;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_CYCLES - 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkout_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_cnt  <= 32'd0;
      turn_cnt   <= 4'd0;
      lock_rec   <= 1'b0;
      lock_play  <= 1'b0;
      play_gnt_q <= 1'b0;
      play_rdata <= 32'd0;
    end else begin
      state_q <= state_d;
      // Any state change restarts the grant count, so each grant starts at zero.
      if (state_d != state_q)                     grant_cnt <= 32'd0;
      else if (state_q == REC || state_q == PLAY) grant_cnt <= grant_cnt + 32'd1;
      if (state_q == TURN) turn_cnt <= turn_cnt + 4'd1;
      else                 turn_cnt <= 4'd0;
      // A timeout lock wins over a same-edge release; it clears on the next sampled-low request.
      lock_rec   <= set_lock_rec  | (lock_rec  & rec_req);
      lock_play  <= set_lock_play | (lock_play & play_req);
      play_gnt_q <= play_gnt;
      if (play_gnt_q) play_rdata <= bram_rdata;
    end
  end

  assign rec_gnt   = (state_q == REC);
  assign play_gnt  = (state_q == PLAY);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    bram_we    = 1'b0;
    bram_addr  = 16'd0;
    bram_wdata = 32'd0;
    if (state_q == REC) begin
      bram_we    = rec_we;
      bram_addr  = rec_addr;
      bram_wdata = rec_wdata;
    end else if (state_q == PLAY) begin
      bram_addr = play_addr;
    end
  end

endmodule
